ac_motor_deadtime: RTL and testbench
====================================

Name: ac_motor_deadtime

Overview:
Downstream stage of the PWM comparator: converts one phase's single-bit PWM command into complementary high-side/low-side gate drives.
- Inserts a programmable dead time, in clk cycles, on every commutation.
- Swallows command pulses shorter than the dead time.
- Forces both switches off on disable or fault.
- The three-phase inverter top instantiates one per phase, fed by the comparator outputs for sine1..sine3.

Parameters:
DT_WIDTH, 11, width of dead_time input and internal down-counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  bridge enable; low forces both gates off
pwm_in  in  1  comparator output (1 = high-side on)
dead_time  in  DT_WIDTH  dead time in clk cycles, unsigned
fault  in  1  external fault (overcurrent etc.), level
fault_clear  in  1  single-cycle pulse to clear latched fault
gate_high  out  1  high-side gate command
gate_low  out  1  low-side gate command
dead_active  out  1  high while in a dead-time state
fault_latched  out  1  sticky fault flag

Behaviour:
- Clock and reset: one clock (clk), synchronous active-high reset (reset), per the decision already made for this block.
- Reset: state OFF; gate_high=0, gate_low=0, dead_active=0, fault_latched=0, counter=0.
- Outputs are registers, updated on the same edge as the state from the next-state decode; no combinational path from inputs to outputs.
- States:
  - OFF: both gates 0.
  - LOW_ON: gate_low=1.
  - DT_RISE: both gates 0, heading to high.
  - HIGH_ON: gate_high=1.
  - DT_FALL: both gates 0, heading to low.
- Priority per edge: reset > fault > !enable > normal transitions.
- Fault handling:
  - fault=1 at edge k: fault_latched=1, state OFF, both gates 0 after edge k.
  - While fault_latched=1, stay in OFF regardless of enable.
  - fault_clear=1 with fault=0 clears fault_latched. fault_clear while fault=1 is ignored.
- enable=0: go to OFF immediately (turning off needs no dead time).
- OFF exit (enable=1, fault_latched=0): go to DT_RISE if pwm_in=1, else DT_FALL; load counter. Every enable therefore starts with a full dead time.
- LOW_ON: pwm_in=1 -> DT_RISE, load counter. HIGH_ON: pwm_in=0 -> DT_FALL, load counter.
- Counter load value: dead_time, sampled only on entry to a DT state. Changes to dead_time mid-interval are ignored.
- DT_RISE:
  - pwm_in=0 -> LOW_ON next edge. Pulse swallowed; safe because the high side was never on.
  - else counter<=1 -> HIGH_ON.
  - else decrement.
- DT_FALL: symmetric (pwm_in=1 -> HIGH_ON; counter<=1 -> LOW_ON).
- Dead gap length: exactly max(dead_time,1) cycles of both gates 0. dead_time=0 still gives 1 cycle.
- Timing: pwm_in edge sampled at edge k -> old gate drops after edge k -> new gate rises after edge k+max(dead_time,1).
- dead_active = state in {DT_RISE, DT_FALL}.
- Invariant: gate_high & gate_low never both 1 in any cycle, including reset release, enable toggling and fault.

Decomposition:
- Package ac_motor_pkg: state enum (OFF, LOW_ON, DT_RISE, HIGH_ON, DT_FALL), DT_WIDTH default, DT_MAX constant.
- No sub-module: the counter and FSM are in one block.
- Three instances sit in the inverter top, one per phase.

Test Plan:
- Reset, enable=1, pwm_in=0, dead_time=10 -> after reset release both gates 0 for 10 cycles, then gate_low=1; dead_active high for exactly those 10 cycles.
- Steady LOW_ON, pwm_in rises, dead_time=1000 -> gate_low falls next edge; gate_high rises exactly 1000 cycles later; overlap checker never fires.
- In DT_RISE with dead_time=100, pwm_in pulses high for 40 cycles -> gate_high never asserts; gate_low returns 1 the edge after pwm_in falls.
- dead_time=0 and dead_time=1 with pwm_in toggling every 8 cycles -> exactly 1 both-off cycle per commutation.
- HIGH_ON, fault=1 for 1 cycle -> both gates 0 next edge, fault_latched=1. fault_clear while fault=1 is ignored. fault_clear after fault=0 -> restart via a full dead time.
- Change dead_time 200 -> 50 midway through a dead interval -> current gap remains 200; the next commutation uses 50.

Source files
------------

// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the per-phase dead-time inserter.
package ac_motor_pkg;

  localparam int DT_WIDTH_DEF = 11;
  localparam int DT_MAX       = (1 << DT_WIDTH_DEF) - 1;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LOW_ON  = 3'd1,
    DT_RISE = 3'd2,
    HIGH_ON = 3'd3,
    DT_FALL = 3'd4
  } state_e;

endpackage

// File: rtl/ac_motor_deadtime.sv
// One inverter phase: PWM command -> complementary gate drives with dead time,
// short-pulse swallowing, and a sticky fault that holds both switches off.
module ac_motor_deadtime
  import ac_motor_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clear,
  output logic                gate_high,
  output logic                gate_low,
  output logic                dead_active,
  output logic                fault_latched
);

  state_e              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                fault_latched_q, fault_latched_d;
  logic                gate_high_q, gate_low_q, dead_active_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fault_latched_d = fault_latched_q;
    if (fault) begin
      fault_latched_d = 1'b1;
      state_d         = OFF;
    end else if (fault_latched_q) begin
      // The clearing edge itself still holds OFF; restart begins one edge later.
      state_d = OFF;
      if (fault_clear) fault_latched_d = 1'b0;
    end else if (!enable) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          state_d = pwm_in ? DT_RISE : DT_FALL;
          cnt_d   = dead_time;
        end
        LOW_ON: begin
          if (pwm_in) begin
            state_d = DT_RISE;
            cnt_d   = dead_time;
          end
        end
        HIGH_ON: begin
          if (!pwm_in) begin
            state_d = DT_FALL;
            cnt_d   = dead_time;
          end
        end
        DT_RISE: begin
          if (!pwm_in)                       state_d = LOW_ON;
          else if (cnt_q <= DT_WIDTH'(1))    state_d = HIGH_ON;
          else                               cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        DT_FALL: begin
          if (pwm_in)                        state_d = HIGH_ON;
          else if (cnt_q <= DT_WIDTH'(1))    state_d = LOW_ON;
          else                               cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        default: state_d = OFF;
      endcase
    end
  end

  // Gate outputs are decoded from the next state so they register on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= OFF;
      cnt_q           <= '0;
      fault_latched_q <= 1'b0;
      gate_high_q     <= 1'b0;
      gate_low_q      <= 1'b0;
      dead_active_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fault_latched_q <= fault_latched_d;
      gate_high_q     <= (state_d == HIGH_ON);
      gate_low_q      <= (state_d == LOW_ON);
      dead_active_q   <= (state_d == DT_RISE) || (state_d == DT_FALL);
    end
  end

  assign gate_high     = gate_high_q;
  assign gate_low      = gate_low_q;
  assign dead_active   = dead_active_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_ac_motor_deadtime.sv
// Directed plus randomized bench for ac_motor_deadtime against a side/gap reference model.
module tb_ac_motor_deadtime;

  logic        clk = 1'b0;
  logic        reset, enable, pwm_in, fault, fault_clear;
  logic [10:0] dead_time;
  logic        gate_high, gate_low, dead_active, fault_latched;

  int n_cmp = 0;
  int n_err = 0;

  // Model: side currently driven (0 none, 1 low, 2 high), pending target side of a gap, cycles left.
  int m_side = 0;
  int m_tgt  = 0;
  int m_rem  = 0;
  int m_fl   = 0;

  always #5 clk = ~clk;

  ac_motor_deadtime #(.DT_WIDTH(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .dead_time    (dead_time),
    .fault        (fault),
    .fault_clear  (fault_clear),
    .gate_high    (gate_high),
    .gate_low     (gate_low),
    .dead_active  (dead_active),
    .fault_latched(fault_latched)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int want;
    if (reset) begin
      m_side = 0; m_tgt = 0; m_rem = 0; m_fl = 0;
    end else if (fault) begin
      m_fl = 1; m_side = 0; m_tgt = 0;
    end else if (m_fl != 0) begin
      if (fault_clear) m_fl = 0;
      m_side = 0; m_tgt = 0;
    end else if (!enable) begin
      m_side = 0; m_tgt = 0;
    end else begin
      want = pwm_in ? 2 : 1;
      if (m_tgt != 0) begin
        if (want != m_tgt) begin
          m_side = want; m_tgt = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_side = m_tgt; m_tgt = 0;
          end
        end
      end else if (m_side != want) begin
        m_side = 0;
        m_tgt  = want;
        m_rem  = (dead_time == 0) ? 1 : int'(dead_time);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("gate_high", gate_high, (m_side == 2) ? 1 : 0);
    chk("gate_low", gate_low, (m_side == 1) ? 1 : 0);
    chk("dead_active", dead_active, (m_tgt != 0) ? 1 : 0);
    chk("fault_latched", fault_latched, m_fl);
    chk("overlap", gate_high & gate_low, 0);
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (gate_high || gate_low) break;
      n++;
    end
  endtask

  initial begin
    int n, n1, n2;
    logic seen_high;

    reset = 1'b1; enable = 1'b1; pwm_in = 1'b0; dead_time = 11'd10;
    fault = 1'b0; fault_clear = 1'b0;
    repeat (3) cycle();
    chk("reset_gates", {gate_high, gate_low, dead_active, fault_latched}, 0);

    // Reset release with pwm low: full dead time before the low side turns on.
    reset = 1'b0;
    measure_gap(n);
    chk("release_gap", n, 10);
    chk("release_low", gate_low, 1);

    // Long rising dead time.
    repeat (3) cycle();
    dead_time = 11'd1000; pwm_in = 1'b1;
    measure_gap(n);
    chk("rise_gap_1000", n, 1000);
    chk("rise_high", gate_high, 1);

    // Falling with dt=100, then a 40-cycle pulse that must be swallowed.
    dead_time = 11'd100; pwm_in = 1'b0;
    measure_gap(n);
    chk("fall_gap_100", n, 100);
    pwm_in = 1'b1;
    seen_high = 1'b0;
    repeat (40) begin
      cycle();
      seen_high |= gate_high;
    end
    chk("swallow_no_high", seen_high, 0);
    pwm_in = 1'b0;
    cycle();
    chk("swallow_low_back", gate_low, 1);

    // dt=0 and dt=1 both give exactly one off cycle per commutation.
    for (int d = 0; d < 2; d++) begin
      dead_time = 11'(d);
      for (int t = 0; t < 4; t++) begin
        pwm_in = ~pwm_in;
        measure_gap(n);
        chk("min_gap", n, 1);
        repeat (6) cycle();
      end
    end

    // Fault from HIGH_ON, clear ignored while fault persists, then restart.
    dead_time = 11'd5; pwm_in = 1'b1;
    measure_gap(n);
    chk("pre_fault_gap", n, 5);
    fault = 1'b1;
    cycle();
    chk("fault_high_off", gate_high, 0);
    chk("fault_flag", fault_latched, 1);
    fault_clear = 1'b1;
    cycle();
    chk("clear_ignored", fault_latched, 1);
    fault = 1'b0; fault_clear = 1'b0;
    cycle();
    chk("fault_hold_off", gate_high, 0);
    fault_clear = 1'b1;
    cycle();
    chk("fault_cleared", fault_latched, 0);
    fault_clear = 1'b0;
    measure_gap(n);
    chk("restart_gap", n, 5);
    chk("restart_high", gate_high, 1);

    // Mid-gap dead_time change is ignored for the current gap only.
    pwm_in = 1'b0;
    measure_gap(n);
    dead_time = 11'd200; pwm_in = 1'b1;
    n1 = 0;
    repeat (100) begin
      cycle();
      if (!gate_high && !gate_low) n1++;
    end
    dead_time = 11'd50;
    measure_gap(n2);
    chk("gap_kept_200", n1 + n2, 200);
    pwm_in = 1'b0;
    measure_gap(n);
    chk("gap_next_50", n, 50);

    // Disable drops gates at once; re-enable starts with a full dead time.
    enable = 1'b0;
    cycle();
    chk("disable_off", gate_low, 0);
    enable = 1'b1;
    measure_gap(n);
    chk("reenable_gap", n, 50);

    // Randomized traffic checked cycle-by-cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 11) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 49) == 0) dead_time = 11'($urandom_range(0, 20));
      fault       = ($urandom_range(0, 299) == 0);
      fault_clear = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
